speck_decrypt_core: RTL and testbench

Iterative Speck64/128 decryption engine. It consumes the flattened round-key vector produced by the key-schedule block and inverts one Speck round per clock, walking the keys from last to first. It sits on the receive/decrypt side of the UART crypto datapath, beside the encryption core, and shares the key schedule's start/busy/done handshake style.

---
 rtl/speck_decrypt_core.sv | 98 +++++++++
 tb/tb_speck_decrypt_core.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/speck_decrypt_core.sv
// Iterative Speck64/128 decryption: one inverse round per clock, round keys walked last to first.
// Build option SPECK_DEC_KEY_LATCH_EN snapshots rk_flat on start instead of reading it live.
module speck_decrypt_core #(
   parameter int W      = 32,
   parameter int ROUNDS = 27
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [W*ROUNDS-1:0] rk_flat,
   input  logic [W-1:0]        ct_x,
   input  logic [W-1:0]        ct_y,
   output logic [W-1:0]        pt_x,
   output logic [W-1:0]        pt_y,
   output logic                busy,
   output logic                done
);
   localparam int            RW     = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
   localparam logic [RW-1:0] R_LAST = RW'(ROUNDS - 1);

   typedef enum logic {IDLE, RUN} state_t;
   state_t state, state_nxt;

   logic [W-1:0]             x, y, k, mix, diff, x_nxt, y_nxt;
   logic [RW-1:0]            r;
   logic                     accept, last;
   logic [ROUNDS-1:0][W-1:0] rk;

`ifdef SPECK_DEC_KEY_LATCH_EN
   always_ff @(posedge clk) begin
      if (rst)         rk <= '0;
      else if (accept) rk <= rk_flat;
   end
`else
   assign rk = rk_flat;
`endif

   assign k = rk[r];

   // Inverse round: undo y = ROL(y,3)^x first, then x = (ROR(x,8)+y)^k.
   assign mix   = y ^ x;
   assign y_nxt = {mix[2:0], mix[W-1:3]};
   assign diff  = (x ^ k) - y_nxt;
   assign x_nxt = {diff[W-9:0], diff[W-1:W-8]};

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      last      = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            accept = start;
            if (start) state_nxt = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (r == '0) begin
               last      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x    <= '0;
         y    <= '0;
         r    <= '0;
         pt_x <= '0;
         pt_y <= '0;
         done <= 1'b0;
      end else begin
         done <= last;
         if (accept) begin
            x <= ct_x;
            y <= ct_y;
            r <= R_LAST;
         end else if (busy) begin
            if (last) begin
               pt_x <= x_nxt;
               pt_y <= y_nxt;
            end else begin
               x <= x_nxt;
               y <= y_nxt;
               r <= r - 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_speck_decrypt_core.sv
// Randomized self-checking bench for speck_decrypt_core against a Speck64/128 reference model.
module tb_speck_decrypt_core;
   localparam int W      = 32;
   localparam int ROUNDS = 27;
   localparam logic [31:0] KAT_CX = 32'h8c6fa548;
   localparam logic [31:0] KAT_CY = 32'h454e028b;
   localparam logic [63:0] KAT_PT = 64'h3b726574_7475432d;

   logic                clk = 1'b0;
   logic                rst, start;
   logic [W*ROUNDS-1:0] rk_flat;
   logic [W-1:0]        ct_x, ct_y, pt_x, pt_y;
   logic                busy, done;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] rk_m [ROUNDS];

   speck_decrypt_core #(.W(W), .ROUNDS(ROUNDS)) dut (
      .clk(clk), .rst(rst), .start(start), .rk_flat(rk_flat),
      .ct_x(ct_x), .ct_y(ct_y), .pt_x(pt_x), .pt_y(pt_y),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] ror(input logic [31:0] v, input int n);
      return (v >> n) | (v << (32 - n));
   endfunction

   function automatic logic [31:0] rol(input logic [31:0] v, input int n);
      return (v << n) | (v >> (32 - n));
   endfunction

   // Speck64/128 key expansion; drives rk_flat with the result.
   task automatic make_keys(input logic [31:0] k0, k1, k2, k3);
      logic [31:0] l[$];
      logic [31:0] k;
      l.push_back(k1);
      l.push_back(k2);
      l.push_back(k3);
      k = k0;
      rk_m[0] = k;
      for (int i = 0; i < ROUNDS - 1; i++) begin
         l.push_back((k + ror(l[i], 8)) ^ i);
         k = rol(k, 3) ^ l[i + 3];
         rk_m[i + 1] = k;
      end
      for (int j = 0; j < ROUNDS; j++) rk_flat[j*W +: W] = rk_m[j];
   endtask

   function automatic logic [63:0] encrypt(input logic [31:0] x0, y0);
      logic [31:0] x, y;
      x = x0;
      y = y0;
      for (int i = 0; i < ROUNDS; i++) begin
         x = (ror(x, 8) + y) ^ rk_m[i];
         y = rol(y, 3) ^ x;
      end
      return {x, y};
   endfunction

   // Decryption where only the last n_live keys are real and the rest read as zero.
   function automatic logic [63:0] decrypt_partial(input logic [31:0] x0, y0, input int n_live);
      logic [31:0] x, y, kk;
      x = x0;
      y = y0;
      for (int i = ROUNDS - 1; i >= 0; i--) begin
         kk = (i >= ROUNDS - n_live) ? rk_m[i] : 32'h0;
         y  = ror(y ^ x, 3);
         x  = rol((x ^ kk) - y, 8);
      end
      return {x, y};
   endfunction

   // Pulse start, then wait (bounded) for done; returns at the done cycle.
   task automatic run(input logic [31:0] cx, cy, input string tag);
      int cyc;
      ct_x  = cx;
      ct_y  = cy;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      cyc = 0;
      while (!done && cyc < 60) begin
         tick();
         cyc++;
      end
      chk({tag, "_lat"}, 64'(cyc), 64'd27);
      chk({tag, "_busy_end"}, 64'(busy), 64'd0);
   endtask

   initial begin
      int          cyc, ndone, dcyc;
      logic [63:0] c, dpt, exp;
      logic [31:0] px, py;

      rst = 1'b1; start = 1'b0; ct_x = '0; ct_y = '0; rk_flat = '0;
      tick();
      tick();
      chk("rst_pt", {pt_x, pt_y}, 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      rst = 1'b0;

      // known answer
      make_keys(32'h03020100, 32'h0b0a0908, 32'h13121110, 32'h1b1a1918);
      run(KAT_CX, KAT_CY, "kat");
      chk("kat_pt", {pt_x, pt_y}, KAT_PT);
      tick();
      chk("kat_done_width", 64'(done), 64'd0);
      chk("kat_hold", {pt_x, pt_y}, KAT_PT);

      // starts during a run are ignored
      ct_x = KAT_CX; ct_y = KAT_CY; start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 0; ndone = 0; dcyc = -1; dpt = '0;
      while (cyc < 40) begin
         if (cyc == 4 || cyc == 25) begin
            start = 1'b1;
            ct_x  = $urandom;
            ct_y  = $urandom;
         end else start = 1'b0;
         tick();
         cyc++;
         if (done) begin
            ndone++;
            if (dcyc < 0) begin
               dcyc = cyc;
               dpt  = {pt_x, pt_y};
            end
         end
      end
      start = 1'b0;
      chk("bi_ndone", 64'(ndone), 64'd1);
      chk("bi_lat", 64'(dcyc), 64'd27);
      chk("bi_pt", dpt, KAT_PT);

      // back-to-back: second start issued in the done cycle
      run(KAT_CX, KAT_CY, "b2b_a");
      chk("b2b_a_pt", {pt_x, pt_y}, KAT_PT);
      run(KAT_CX, KAT_CY, "b2b_b");
      chk("b2b_b_pt", {pt_x, pt_y}, KAT_PT);
      tick();

      // reset in the middle of a run
      ct_x = KAT_CX; ct_y = KAT_CY; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 1; i < 10; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mr_pt", {pt_x, pt_y}, 64'd0);
      chk("mr_busy", 64'(busy), 64'd0);
      chk("mr_done", 64'(done), 64'd0);
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done) ndone++;
      end
      chk("mr_nodone", 64'(ndone), 64'd0);
      run(KAT_CX, KAT_CY, "mr_post");
      chk("mr_post_pt", {pt_x, pt_y}, KAT_PT);
      tick();

      // round trip under random keys
      for (int n = 0; n < 100; n++) begin
         make_keys($urandom, $urandom, $urandom, $urandom);
         px = $urandom;
         py = $urandom;
         c  = encrypt(px, py);
         run(c[63:32], c[31:0], "rt");
         chk("rt_pt", {pt_x, pt_y}, {px, py});
      end
      tick();

      // round keys zeroed after the first round has consumed its key
      make_keys(32'h03020100, 32'h0b0a0908, 32'h13121110, 32'h1b1a1918);
      ct_x = KAT_CX; ct_y = KAT_CY; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rk_flat = '0;
      cyc = 1;
      while (!done && cyc < 60) begin
         tick();
         cyc++;
      end
      chk("kl_lat", 64'(cyc), 64'd27);
`ifdef SPECK_DEC_KEY_LATCH_EN
      exp = KAT_PT;
`else
      exp = decrypt_partial(KAT_CX, KAT_CY, 1);
`endif
      chk("kl_pt", {pt_x, pt_y}, exp);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
